shift_register_universal: RTL and testbench
===========================================

# shift_register_universal

Parametrised universal shift register: the successor to the fixed 8-bit right/left/load shifter. It adds generic width, rotate, arithmetic right shift, a hold/enable control, and an autonomous multi-step burst shift sequenced by a small FSM. It serves as the shared shift/serialise primitive for datapath shifts and serial interfaces in the core.

## Interface
- WIDTH, 8, register width in bits (≥2).
- CNT_W, 4, width of burst step count (≥1).
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  clock enable; low freezes register, FSM and counter.
- control  in  3  operation select (see Operation).
- start  in  1  request burst execution of `control` for `burst_count` steps.
- burst_count  in  CNT_W  number of burst steps.
- serial_in_msb  in  1  bit entering at MSB on right shift.
- serial_in_lsb  in  1  bit entering at LSB on left shift.
- parallel_load  in  WIDTH  load value.
- parallel_read  out  WIDTH  register contents.
- serial_out_lsb  out  1  = parallel_read[0].
- serial_out_msb  out  1  = parallel_read[WIDTH-1].
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.

## Operation
- control encoding:
  - 000 shift right, MSB ← serial_in_msb.
  - 001 shift left, LSB ← serial_in_lsb.
  - 010 parallel load.
  - 011 hold.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right (MSB replicated; serial_in ignored).
  - 111 hold (reserved).
- FSM states:
  - IDLE: if enable=1 and start=0, apply control at the edge.
  - IDLE, enable=1, start=1, control ∈ {000,001,100,101,110}: capture op and burst_count, go to RUN; no register change at this edge.
  - IDLE, start=1 with control ∈ {010,011,111}: start is ignored and control executes as an immediate op.
  - RUN: apply the captured op once per enabled edge and decrement the counter. control, start, parallel_load and burst_count are ignored in this state.
  - RUN → DONE after the final step. burst_count=0 performs zero shifts and goes directly to DONE on the first RUN edge.
  - DONE: done=1 for one cycle; next enabled edge → IDLE. A start in DONE is ignored.
- Serial inputs are sampled live on each RUN step, not captured at start.
- serial_out_lsb/serial_out_msb are combinational from the register. For the current op, they show the bit that leaves the register.

## Timing
- Reset (reset_n=0 at an edge): parallel_read=0, serial outputs 0, busy=0, done=0, FSM=IDLE, counter=0.
- Reset takes priority over enable and aborts a burst mid-operation with no done pulse.
- Immediate op: result visible one edge after it is sampled.
- Burst of N steps with start sampled at edge E0:
  - Shifts occur at E1..EN.
  - busy=1 from after E0 through EN.
  - done=1 between EN+1 and EN+2; burst_count=0 gives done after E1.
  - Total latency from start to done: N+1 edges.
- enable=0 stalls every state, including DONE, so the done pulse stretches. No step is lost.
- done and busy are registered outputs; they are never high together.

## Configuration
- SHIFT_REG_ROTATE_EN defined: codes 100/101 rotate, both immediate and burst.
- SHIFT_REG_ROTATE_EN not defined: 100/101 act as hold, and start with 100/101 is ignored. All other behaviour is unchanged.

## Test plan
- Reset with reset_n=0 for one edge after random activity → parallel_read=0x00, busy=0, done=0. (WIDTH=8 for all scenarios.)
- Load 0x69, then shift right with serial_in_msb=0 → 0x69 then 0x34; serial_out_lsb=1 before the shift, 0 after. Then shift left with serial_in_lsb=1 from 0x69 → 0xD3.
- Load 0x96, then control 110 → 0xCB.
- Burst rotate left with start, burst_count=3 on 0x69 (macro defined) → 0xD2, 0xA5, 0x4B on E1..E3; busy over E1..E3; done for one cycle after E4. Repeat with enable=0 for two cycles mid-burst → same values, done delayed by 2.
- Burst count 0 → no change, done after E1. reset_n=0 at E2 of a 5-step burst → register 0, busy=0, no done.
- Macro undefined: control 100 on 0x69 → stays 0x69; start with 101 → ignored, busy stays 0.

Source files
------------

// File: rtl/shift_register_universal_if.sv
// Signal bundle for the universal shift register: controls, serial/parallel data and status.
// Latency: none, this is wiring only.
// Backpressure: none in the bundle; stalls travel on the enable signal.
interface shift_register_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             enable;
  logic [2:0]       control;
  logic             start;
  logic [CNT_W-1:0] burst_count;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic [WIDTH-1:0] parallel_load;
  logic [WIDTH-1:0] parallel_read;
  logic             serial_out_lsb;
  logic             serial_out_msb;
  logic             busy;
  logic             done;

  // The master drives controls and data in and observes the register.
  modport master (
    output enable, control, start, burst_count, serial_in_msb, serial_in_lsb, parallel_load,
    input  parallel_read, serial_out_lsb, serial_out_msb, busy, done
  );

  // The shift register itself.
  modport slave (
    input  enable, control, start, burst_count, serial_in_msb, serial_in_lsb, parallel_load,
    output parallel_read, serial_out_lsb, serial_out_msb, busy, done
  );
endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: shift, rotate, arithmetic shift, load and hold, plus an FSM-driven burst mode.
// Latency: an immediate op shows one edge after it is sampled; an N-step burst raises done N+1 edges after start.
// Backpressure: enable=0 freezes register, FSM and counter in every state. Rotate ops need SHIFT_REG_ROTATE_EN.
module shift_register_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                     clock,
  input logic                     reset_n,
  shift_register_universal_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  logic [1:0]       state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             busy_q;
  logic             done_q;
  logic             burst_ok;

  // Next register value for one step of op. Hold codes (011, 111) fall to the default.
  // When rotation is compiled out, 100 and 101 fall to the default as well.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sin_msb,
    input logic             sin_lsb,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      OP_SHR:  nxt = {sin_msb, cur[WIDTH-1:1]};
      OP_SHL:  nxt = {cur[WIDTH-2:0], sin_lsb};
      OP_LOAD: nxt = ld;
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
`endif
      OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only the shifting ops can run as a burst. A start with any other code runs that code as an immediate op.
  always_comb begin
    burst_ok = 1'b0;
    case (bus.control)
      OP_SHR, OP_SHL, OP_ASR: burst_ok = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROR, OP_ROL:         burst_ok = 1'b1;
`endif
      default:                burst_ok = 1'b0;
    endcase
  end

  // Register, burst FSM and step counter. Reset wins over enable and aborts a burst silently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SHR;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && burst_ok) begin
            // The start edge itself only captures the op and count; the register is untouched.
            op_q    <= bus.control;
            cnt_q   <= bus.burst_count;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end else begin
            data_q <= apply_op(bus.control, data_q, bus.serial_in_msb,
                               bus.serial_in_lsb, bus.parallel_load);
          end
        end
        ST_RUN: begin
          // Serial inputs are sampled live here. A count of zero goes straight to DONE.
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            data_q <= apply_op(op_q, data_q, bus.serial_in_msb,
                               bus.serial_in_lsb, bus.parallel_load);
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.parallel_read  = data_q;
  assign bus.serial_out_lsb = data_q[0];
  assign bus.serial_out_msb = data_q[WIDTH-1];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8). Expected register values are queued when driven.
// Each queued value is popped and compared after the edge. Rotate checks follow SHIFT_REG_ROTATE_EN.
module tb_shift_register_universal;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  shift_register_universal_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_register_universal #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [2:0] burst_op;
  logic [7:0] bv[3];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed=empty scoreboard expected=queued value", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, bus.parallel_read, e);
    end
  endtask

  task automatic flags(input string tag, input logic b, input logic d);
    chk({tag, ".busy"}, bus.busy, b);
    chk({tag, ".done"}, bus.done, d);
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [7:0] ld, input logic st, input logic [3:0] cnt);
    bus.control       = ctl;
    bus.parallel_load = ld;
    bus.start         = st;
    bus.burst_count   = cnt;
  endtask

  // One edge with the given inputs, then check the register against the queued value.
  task automatic step(input string tag, input logic [2:0] ctl, input logic [7:0] ld,
                      input logic st, input logic [3:0] cnt, input logic [7:0] exp_v);
    drive(ctl, ld, st, cnt);
    sb.push_back(exp_v);
    tick();
    pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable        = 1'b1;
    bus.serial_in_msb = 1'b0;
    bus.serial_in_lsb = 1'b0;
    drive(3'b011, 8'h00, 1'b0, 4'd0);

    // Random immediate activity, then reset while enable is low and a start is pending.
    for (int i = 0; i < 6; i++) begin
      bus.control       = 3'($urandom_range(0, 7));
      bus.parallel_load = 8'($urandom);
      bus.serial_in_msb = 1'($urandom);
      bus.serial_in_lsb = 1'($urandom);
      tick();
    end
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    step("reset", 3'b010, 8'hFF, 1'b1, 4'd3, 8'h00);
    flags("reset", 1'b0, 1'b0);
    chk("reset.sol", bus.serial_out_lsb, 1'b0);
    chk("reset.som", bus.serial_out_msb, 1'b0);
    reset_n    = 1'b1;
    bus.enable = 1'b1;

    // Immediate load, right/left shift, arithmetic shift.
    bus.serial_in_msb = 1'b0;
    bus.serial_in_lsb = 1'b1;
    step("load69", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    chk("load69.sol", bus.serial_out_lsb, 1'b1);
    step("shr", 3'b000, 8'h00, 1'b0, 4'd0, 8'h34);
    chk("shr.sol", bus.serial_out_lsb, 1'b0);
    step("reload69", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    step("shl", 3'b001, 8'h00, 1'b0, 4'd0, 8'hD3);
    chk("shl.som", bus.serial_out_msb, 1'b1);
    bus.serial_in_msb = 1'b1;
    step("load96", 3'b010, 8'h96, 1'b0, 4'd0, 8'h96);
    step("asr", 3'b110, 8'h00, 1'b0, 4'd0, 8'hCB);
    step("hold7", 3'b111, 8'h00, 1'b0, 4'd0, 8'hCB);

`ifdef SHIFT_REG_ROTATE_EN
    burst_op = 3'b101;
    bv = '{8'hD2, 8'hA5, 8'h4B};
    step("load69r", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    step("ror", 3'b100, 8'h00, 1'b0, 4'd0, 8'hB4);
`else
    burst_op = 3'b001;
    bv = '{8'hD3, 8'hA7, 8'h4F};
    step("load69r", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    step("ror_off", 3'b100, 8'h00, 1'b0, 4'd0, 8'h69);
    step("rol_start_off", 3'b101, 8'h00, 1'b1, 4'd3, 8'h69);
    flags("rol_start_off", 1'b0, 1'b0);
    step("rol_start_off2", 3'b011, 8'h00, 1'b0, 4'd0, 8'h69);
    flags("rol_start_off2", 1'b0, 1'b0);
`endif

    // Three-step burst; control/load/start changes during RUN must be ignored.
    bus.serial_in_lsb = 1'b1;
    step("b.load", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    step("b.e0", burst_op, 8'h00, 1'b1, 4'd3, 8'h69);
    flags("b.e0", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("b.e%0d", i + 1), 3'b010, 8'hFF, 1'b1, 4'd9, bv[i]);
      flags($sformatf("b.e%0d", i + 1), 1'b1, 1'b0);
    end
    step("b.e4", 3'b011, 8'h00, 1'b0, 4'd0, bv[2]);
    flags("b.e4", 1'b0, 1'b1);
    step("b.e5", 3'b011, 8'h00, 1'b0, 4'd0, bv[2]);
    flags("b.e5", 1'b0, 1'b0);

    // Same burst with two stalled edges mid-run and one stalled edge while done is high.
    step("s.load", 3'b010, 8'h69, 1'b0, 4'd0, 8'h69);
    step("s.e0", burst_op, 8'h00, 1'b1, 4'd3, 8'h69);
    step("s.e1", 3'b011, 8'h00, 1'b0, 4'd0, bv[0]);
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step("s.stall", 3'b010, 8'hFF, 1'b0, 4'd0, bv[0]);
      flags("s.stall", 1'b1, 1'b0);
    end
    bus.enable = 1'b1;
    step("s.e2", 3'b011, 8'h00, 1'b0, 4'd0, bv[1]);
    step("s.e3", 3'b011, 8'h00, 1'b0, 4'd0, bv[2]);
    flags("s.e3", 1'b1, 1'b0);
    step("s.e4", 3'b011, 8'h00, 1'b0, 4'd0, bv[2]);
    flags("s.e4", 1'b0, 1'b1);
    bus.enable = 1'b0;
    step("s.done_stall", 3'b011, 8'h00, 1'b1, 4'd0, bv[2]);
    flags("s.done_stall", 1'b0, 1'b1);
    bus.enable = 1'b1;
    step("s.idle", 3'b011, 8'h00, 1'b0, 4'd0, bv[2]);
    flags("s.idle", 1'b0, 1'b0);

    // Zero-length burst: no change, done right after the first RUN edge.
    step("z.load", 3'b010, 8'h5A, 1'b0, 4'd0, 8'h5A);
    step("z.e0", 3'b000, 8'h00, 1'b1, 4'd0, 8'h5A);
    flags("z.e0", 1'b1, 1'b0);
    step("z.e1", 3'b011, 8'h00, 1'b0, 4'd0, 8'h5A);
    flags("z.e1", 1'b0, 1'b1);
    step("z.e2", 3'b011, 8'h00, 1'b0, 4'd0, 8'h5A);
    flags("z.e2", 1'b0, 1'b0);

    // Five-step right-shift burst: serial input sampled live, then reset at E2 aborts with no done.
    bus.serial_in_msb = 1'b0;
    step("a.load", 3'b010, 8'hA5, 1'b0, 4'd0, 8'hA5);
    step("a.e0", 3'b000, 8'h00, 1'b1, 4'd5, 8'hA5);
    bus.serial_in_msb = 1'b1;
    step("a.e1", 3'b011, 8'h00, 1'b0, 4'd0, 8'hD2);
    flags("a.e1", 1'b1, 1'b0);
    reset_n = 1'b0;
    step("a.e2_reset", 3'b011, 8'h00, 1'b0, 4'd0, 8'h00);
    flags("a.e2_reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("a.after", 3'b011, 8'h00, 1'b0, 4'd0, 8'h00);
      flags("a.after", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
